// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared widths and result record for the multiplier result path
// Purpose: default product width and result FIFO depth, plus the {ov, data} record
//          used wherever a single result entry is handled as one value.
// Ports:   none (package)
package fpm_pkg;
  localparam int FPM_WIDTH     = 32;
  localparam int FPM_RES_DEPTH = 8;

  typedef struct packed {
    logic                 ov;
    logic [FPM_WIDTH-1:0] data;
  } fpm_result_t;
endpackage

// File: rtl/fpm_result_fifo_if.sv
// rtl/fpm_result_fifo_if.sv - valid/ready read port of the result FIFO
// Purpose: groups the head-of-queue handshake towards the result sink.
// Ports:   rd_valid/rd_data/rd_ov driven by the FIFO (master),
//          rd_ready driven by the sink (slave).
interface fpm_result_fifo_if #(
  parameter int WIDTH = fpm_pkg::FPM_WIDTH
);
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ov;

  modport master (output rd_valid, output rd_data, output rd_ov, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_ov, output rd_ready);
endinterface

// File: rtl/fpm_sync_fifo.sv
// rtl/fpm_sync_fifo.sv - circular-buffer FIFO with registered occupancy flags
// Purpose: DEPTH x W storage, read/write pointers, exact count/full/empty.
// Ports:   clk, reset (async, active-low), clear (sync flush),
//          push/wr_data write side, pop/rd_data read side (head is combinational
//          from registered storage), count/full/empty status.
module fpm_sync_fifo #(
  parameter  int W     = 33,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  // A pop frees the slot in the same cycle, so a push at full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CW'(1);
    else if (do_pop && !do_push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is reset so the head reads as zero out of reset; clear only
  // rewinds the pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end
endmodule

// File: rtl/fpm_result_fifo.sv
// rtl/fpm_result_fifo.sv - aligns products with their late overflow flag and queues them
// Purpose: stage register pairs c_data with ov_in one cycle later, pushes the
//          {ov, data} pair into the FIFO, counts drops at full, keeps a sticky overflow.
// Ports:   clk, reset (async, active-low), clear (sync flush),
//          c_data/c_valid product input, ov_in/ov_valid overflow input,
//          rd (master modport: rd_valid/rd_ready/rd_data/rd_ov),
//          count/full/empty occupancy, drop_cnt (saturating), ov_sticky.
module fpm_result_fifo
  import fpm_pkg::*;
#(
  parameter  int WIDTH  = FPM_WIDTH,
  parameter  int DEPTH  = FPM_RES_DEPTH,
  parameter  int DROP_W = 8,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  c_data,
  input  logic              c_valid,
  input  logic              ov_in,
  input  logic              ov_valid,
  fpm_result_fifo_if.master rd,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              ov_sticky
);
  logic [WIDTH-1:0] stage_data;
  logic             stage_v;
  logic             ov;
  logic             pop;
  logic             drop;
  logic [WIDTH:0]   head;

  assign ov  = ov_valid & ov_in;
  assign pop = rd.rd_valid & rd.rd_ready;
  // A staged product is lost only when the FIFO is full and nothing leaves.
  assign drop = stage_v & full & ~pop;

  assign rd.rd_valid = ~empty;
  assign rd.rd_ov    = head[WIDTH];
  assign rd.rd_data  = head[WIDTH-1:0];

  fpm_sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (stage_v),
    .pop     (rd.rd_ready),
    .wr_data ({ov, stage_data}),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_data <= '0;
      stage_v    <= 1'b0;
      drop_cnt   <= '0;
      ov_sticky  <= 1'b0;
    end else if (clear) begin
      stage_v    <= 1'b0;
      drop_cnt   <= '0;
      ov_sticky  <= 1'b0;
    end else begin
      stage_v <= c_valid;
      if (c_valid) stage_data <= c_data;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      // Covers accepted, dropped and orphan overflows alike.
      if (ov) ov_sticky <= 1'b1;
    end
  end
endmodule
